// File: rtl/rf_wb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
package rf_wb_pkg;

    typedef enum logic [1:0] {WB_SLOT_NONE, WB_SLOT_A, WB_SLOT_B} wb_slot_e;

    function automatic int next_ptr(input int last_idx, input int num_ch);
        return (last_idx + 1 >= num_ch) ? 0 : last_idx + 1;
    endfunction

endpackage

// File: rtl/rf_wb_rr_pick.sv
// Round-robin pick: first set bit of req at or after ptr, wrapping around.
module rf_wb_rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx
);

    int j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = PW'(j);
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Collects writes from NUM_CH producers and issues up to two per cycle to the RF.
// Optional build macro RF_WB_ARB_ZERO_DROP_EN: swallow writes to register 0.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_CH-1:0]                    ch_valid_i,
    output logic [NUM_CH-1:0]                    ch_ready_o,
    input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    ch_addr_i,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    ch_data_i,
    output logic [ADDR_WIDTH-1:0]                waddr_a_o,
    output logic [DATA_WIDTH-1:0]                wdata_a_o,
    output logic                                 we_a_o,
    output logic [ADDR_WIDTH-1:0]                waddr_b_o,
    output logic [DATA_WIDTH-1:0]                wdata_b_o,
    output logic                                 we_b_o
);

    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]     zero_m, arb_m, mask_b, gnt;
    logic                  found_a, found_b;
    logic [PW-1:0]         idx_a, idx_b;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    wb_slot_e              last_slot;
    logic                  we_a_q, we_a_d, we_b_q, we_b_d;
    logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
    logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;

    always_comb begin
        zero_m = '0;
`ifdef RF_WB_ARB_ZERO_DROP_EN
        for (int i = 0; i < NUM_CH; i++)
            zero_m[i] = ch_valid_i[i] && (ch_addr_i[i] == '0);
`endif
        arb_m = ch_valid_i & ~zero_m;
    end

    rf_wb_rr_pick #(.N(NUM_CH), .PW(PW)) u_pick_a (
        .req(arb_m), .ptr(rr_ptr_q), .found(found_a), .idx(idx_a)
    );

    // Slot A's own bit drops out too, since it trivially matches its own address.
    always_comb begin
        mask_b = '0;
        for (int i = 0; i < NUM_CH; i++)
            mask_b[i] = arb_m[i] && (ch_addr_i[i] != ch_addr_i[idx_a]);
    end

    rf_wb_rr_pick #(.N(NUM_CH), .PW(PW)) u_pick_b (
        .req(mask_b), .ptr(rr_ptr_q), .found(found_b), .idx(idx_b)
    );

    always_comb begin
        gnt = '0;
        if (found_a) gnt[idx_a] = 1'b1;
        if (found_b) gnt[idx_b] = 1'b1;
        ch_ready_o = rst ? '0 : (gnt | zero_m);
    end

    always_comb begin
        last_slot = found_b ? WB_SLOT_B : (found_a ? WB_SLOT_A : WB_SLOT_NONE);
        case (last_slot)
            WB_SLOT_A: rr_ptr_d = PW'(next_ptr(int'(idx_a), NUM_CH));
            WB_SLOT_B: rr_ptr_d = PW'(next_ptr(int'(idx_b), NUM_CH));
            default:   rr_ptr_d = rr_ptr_q;
        endcase
    end

    always_comb begin
        we_a_d    = found_a;
        waddr_a_d = found_a ? ch_addr_i[idx_a] : waddr_a_q;
        wdata_a_d = found_a ? ch_data_i[idx_a] : wdata_a_q;
        we_b_d    = found_b;
        waddr_b_d = found_b ? ch_addr_i[idx_b] : waddr_b_q;
        wdata_b_d = found_b ? ch_data_i[idx_b] : wdata_b_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            we_a_q    <= 1'b0;
            waddr_a_q <= '0;
            wdata_a_q <= '0;
            we_b_q    <= 1'b0;
            waddr_b_q <= '0;
            wdata_b_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            we_a_q    <= we_a_d;
            waddr_a_q <= waddr_a_d;
            wdata_a_q <= wdata_a_d;
            we_b_q    <= we_b_d;
            waddr_b_q <= waddr_b_d;
            wdata_b_q <= wdata_b_d;
        end
    end

    assign we_a_o    = we_a_q;
    assign waddr_a_o = waddr_a_q;
    assign wdata_a_o = wdata_a_q;
    assign we_b_o    = we_b_q;
    assign waddr_b_o = waddr_b_q;
    assign wdata_b_o = wdata_b_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a behavioural register file on its write ports.
module tb_rf_wb_arbiter;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        ch_valid;
    logic [3:0]        ch_ready;
    logic [3:0][4:0]   ch_addr;
    logic [3:0][31:0]  ch_data;
    logic [4:0]        waddr_a, waddr_b;
    logic [31:0]       wdata_a, wdata_b;
    logic              we_a, we_b;

    logic [31:0] rf [32];
    int n_chk = 0;
    int n_fail = 0;
    int cnt [4];

    always #5 clk = ~clk;

    rf_wb_arbiter #(.NUM_CH(4), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ch_valid_i(ch_valid), .ch_ready_o(ch_ready),
        .ch_addr_i(ch_addr), .ch_data_i(ch_data),
        .waddr_a_o(waddr_a), .wdata_a_o(wdata_a), .we_a_o(we_a),
        .waddr_b_o(waddr_b), .wdata_b_o(wdata_b), .we_b_o(we_b)
    );

    // Port B wins on a same-address collision, as in the real register file.
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(posedge clk) begin
        if (we_a) rf[waddr_a] <= wdata_a;
        if (we_b) rf[waddr_b] <= wdata_b;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        ch_valid = '0;
        ch_addr  = '0;
        ch_data  = '0;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        // reset with all channels requesting
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ch_valid[i] = 1'b1;
            ch_addr[i]  = 5'(i + 1);
            ch_data[i]  = 32'h100 + i;
        end
        cyc();
        #3;
        chk("rst_ready", ch_ready, 4'b0000);
        chk("rst_we", {we_a, we_b}, 2'b00);
        chk("rst_addr", {waddr_a, waddr_b}, 10'd0);
        chk("rst_data", {wdata_a, wdata_b}, 64'd0);
        cyc();
        rst = 1'b0;
        #3;
        chk("rel_ready", ch_ready, 4'b0011);
        cyc();
        chk("rel_a", {we_a, waddr_a, wdata_a}, {1'b1, 5'd1, 32'h100});
        chk("rel_b", {we_b, waddr_b, wdata_b}, {1'b1, 5'd2, 32'h101});
        #3;
        chk("rel_ready2", ch_ready, 4'b1100);

        // two distinct addresses in one cycle
        do_reset();
        ch_valid = 4'b0101;
        ch_addr[0] = 5'd3; ch_data[0] = 32'hAAAA;
        ch_addr[2] = 5'd7; ch_data[2] = 32'h5555;
        #3;
        chk("dual_ready", ch_ready, 4'b0101);
        cyc();
        clr_in();
        chk("dual_a", {we_a, waddr_a, wdata_a}, {1'b1, 5'd3, 32'hAAAA});
        chk("dual_b", {we_b, waddr_b, wdata_b}, {1'b1, 5'd7, 32'h5555});
        cyc();
        chk("idle_hold", {we_a, we_b, waddr_a, wdata_a}, {2'b00, 5'd3, 32'hAAAA});
        chk("rf3", rf[3], 32'hAAAA);
        chk("rf7", rf[7], 32'h5555);

        // same-address conflict
        do_reset();
        ch_valid = 4'b0110;
        ch_addr[1] = 5'd9; ch_data[1] = 32'h1111;
        ch_addr[2] = 5'd9; ch_data[2] = 32'h2222;
        #3;
        chk("conf_ready1", ch_ready, 4'b0010);
        cyc();
        ch_valid = 4'b0100;
        chk("conf_a1", {we_a, waddr_a, wdata_a}, {1'b1, 5'd9, 32'h1111});
        chk("conf_b1", we_b, 1'b0);
        #3;
        chk("conf_ready2", ch_ready, 4'b0100);
        cyc();
        clr_in();
        chk("conf_a2", {we_a, waddr_a, wdata_a}, {1'b1, 5'd9, 32'h2222});
        chk("conf_b2", we_b, 1'b0);
        cyc();
        chk("rf9", rf[9], 32'h2222);

        // fairness with all four channels busy
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            ch_valid[i] = 1'b1;
            ch_addr[i]  = 5'(10 + i);
            ch_data[i]  = 32'h200 + i;
        end
        for (int c = 0; c < 8; c++) begin
            #3;
            chk($sformatf("fair_ready%0d", c), ch_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
            for (int k = 0; k < 4; k++) if (ch_ready[k]) cnt[k]++;
            cyc();
        end
        clr_in();
        for (int k = 0; k < 4; k++) chk($sformatf("fair_cnt%0d", k), cnt[k], 4);

        // address 0 handling
        do_reset();
        ch_valid = 4'b0011;
        ch_addr[0] = 5'd0; ch_data[0] = 32'h1234;
        ch_addr[1] = 5'd4; ch_data[1] = 32'h4444;
        #3;
        chk("zero_ready", ch_ready, 4'b0011);
        cyc();
        clr_in();
`ifdef RF_WB_ARB_ZERO_DROP_EN
        chk("zero_a", {we_a, waddr_a, wdata_a}, {1'b1, 5'd4, 32'h4444});
        chk("zero_b", we_b, 1'b0);
        cyc();
        chk("rf0", rf[0], 32'h0);
`else
        chk("zero_a", {we_a, waddr_a, wdata_a}, {1'b1, 5'd0, 32'h1234});
        chk("zero_b", {we_b, waddr_b, wdata_b}, {1'b1, 5'd4, 32'h4444});
        cyc();
        chk("rf0", rf[0], 32'h1234);
`endif
        chk("rf4", rf[4], 32'h4444);

        // reset one cycle after a handshake
        do_reset();
        ch_valid = 4'b0110;
        ch_addr[1] = 5'd20; ch_data[1] = 32'h5A5A;
        ch_addr[2] = 5'd21; ch_data[2] = 32'h6B6B;
        cyc();
        clr_in();
        chk("mid_we_pre", {we_a, we_b}, 2'b11);
        rst = 1'b1;
        #1;
        chk("mid_we_clr", {we_a, we_b}, 2'b00);
        cyc();
        cyc();
        rst = 1'b0;
        chk("mid_rf20", rf[20], 32'h0);
        chk("mid_rf21", rf[21], 32'h0);
        ch_valid = 4'b1111;
        for (int i = 0; i < 4; i++) ch_addr[i] = 5'(24 + i);
        #3;
        chk("mid_ptr0", ch_ready, 4'b0011);
        cyc();
        clr_in();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
